// File: rtl/spi_ram_burst_slave_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_burst_slave_pkg
// Shared types and constants for the SPI RAM burst slave:
//   - state_e : top-level FSM states
//   - cmd_e   : 2-bit frame command encoding
//   - default address/data widths and the frame-length helper
// -----------------------------------------------------------------------------
package spi_ram_burst_slave_pkg;

    localparam int DEF_ADDR_SIZE = 8;
    localparam int DEF_DATA_SIZE = 8;
    localparam int CMD_W         = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX      = 3'd1,
        RD_WAIT = 3'd2,
        RD_LOAD = 3'd3,
        TX      = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        STORE_WR_ADDR = 2'b00,
        WRITE_DATA    = 2'b01,
        STORE_RD_ADDR = 2'b10,
        READ_DATA_    = 2'b11
    } cmd_e;

    // Total bits per frame: command field followed by a full data word.
    function automatic int frame_len(input int data_size);
        return CMD_W + data_size;
    endfunction

endpackage

// File: rtl/spi_ram_burst_slave_frame_rx.sv
// -----------------------------------------------------------------------------
// spi_frame_rx
// Serial-to-parallel frame assembler. Shifts MOSI in MSB first on every
// sampling edge and flags the edge that carries the last bit of a frame.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clear          : drop any partial frame (slave deselected)
//   sample         : this edge samples a MOSI bit
//   mosi           : serial input
//   frame_done     : combinational, high on the edge sampling the last bit
//   frame          : combinational, the complete frame including the bit
//                    being sampled now (valid when frame_done is high)
// -----------------------------------------------------------------------------
module spi_frame_rx #(
    parameter int FRAME_LEN = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 sample,
    input  logic                 mosi,
    output logic                 frame_done,
    output logic [FRAME_LEN-1:0] frame
);

    localparam int CNT_W = $clog2(FRAME_LEN);

    logic [CNT_W-1:0]     bit_cnt_r;
    logic [FRAME_LEN-2:0] shift_r;
    logic                 last_bit_s;

    // The frame is presented including the bit on the wire right now, so the
    // consumer can act on the same edge that samples the final bit.
    assign last_bit_s = (bit_cnt_r == CNT_W'(FRAME_LEN - 1));
    assign frame_done = sample & last_bit_s;
    assign frame      = {shift_r, mosi};

    // Bit counter and shift register; a deselect restarts at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r <= '0;
            shift_r   <= '0;
        end else if (clear) begin
            bit_cnt_r <= '0;
        end else if (sample) begin
            shift_r   <= frame[FRAME_LEN-2:0];
            bit_cnt_r <= last_bit_s ? '0 : bit_cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_ram_burst_slave.sv
// -----------------------------------------------------------------------------
// spi_ram_burst_slave
// SPI slave command front-end that owns the RAM write/read address registers
// and drives a single-port RAM directly. Frames of 2+DATA_SIZE bits arrive
// back-to-back while SS_n is low; READ_DATA returns the RAM word on MISO.
// Ports:
//   clk, rst   : single clock, synchronous active-high reset
//   SS_n       : slave select, active low
//   MOSI/MISO  : serial data in/out, MSB first
//   ram_addr   : RAM address (registered)
//   ram_wdata  : RAM write data (registered)
//   ram_we     : one-cycle write strobe
//   ram_re     : one-cycle read strobe
//   ram_rdata  : RAM read data, valid the cycle after ram_re
//   busy       : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module spi_ram_burst_slave
    import spi_ram_burst_slave_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int AUTO_INC  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [DATA_SIZE-1:0] ram_wdata,
    output logic                 ram_we,
    output logic                 ram_re,
    input  logic [DATA_SIZE-1:0] ram_rdata,
    output logic                 busy
);

    localparam int FRAME_LEN = frame_len(DATA_SIZE);
    localparam int TX_CNT_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    state_e                 state_r;
    state_e                 state_next_s;

    logic                   sample_s;
    logic                   frame_done_s;
    logic [FRAME_LEN-1:0]   frame_s;
    cmd_e                   cmd_s;
    logic [DATA_SIZE-1:0]   payload_s;
    logic [ADDR_SIZE-1:0]   payload_addr_s;
    logic [ADDR_SIZE-1:0]   addr_step_s;

    logic [ADDR_SIZE-1:0]   wr_addr_r;
    logic [ADDR_SIZE-1:0]   rd_addr_r;

    logic [DATA_SIZE-1:0]   tx_shift_r;
    logic [DATA_SIZE-1:0]   tx_shift_next_s;
    logic [TX_CNT_W-1:0]    tx_cnt_r;
    logic                   tx_last_s;

    logic                   miso_r;
    logic                   ram_we_r;
    logic                   ram_re_r;
    logic [ADDR_SIZE-1:0]   ram_addr_r;
    logic [DATA_SIZE-1:0]   ram_wdata_r;

    assign cmd_s           = cmd_e'(frame_s[FRAME_LEN-1 -: CMD_W]);
    assign payload_s       = frame_s[DATA_SIZE-1:0];
    assign payload_addr_s  = payload_s[ADDR_SIZE-1:0];
    // Address arithmetic wraps naturally at 2^ADDR_SIZE.
    assign addr_step_s     = (AUTO_INC != 0) ? ADDR_SIZE'(1) : ADDR_SIZE'(0);
    assign tx_last_s       = (tx_cnt_r == TX_CNT_W'(DATA_SIZE - 1));
    assign tx_shift_next_s = tx_shift_r << 1;

    assign MISO      = miso_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;
    assign ram_we    = ram_we_r;
    assign ram_re    = ram_re_r;
    assign busy      = (state_r != IDLE);

    // Decide which edges sample MOSI. The final TX edge doubles as bit 0 of
    // the next frame so read bursts stay back-to-back.
    always_comb begin
        sample_s = 1'b0;
        if (!SS_n) begin
            case (state_r)
                IDLE, RX: sample_s = 1'b1;
                TX:       sample_s = tx_last_s;
                default:  sample_s = 1'b0;
            endcase
        end else begin
            sample_s = 1'b0;
        end
    end

    spi_frame_rx #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_rx (
        .clk        (clk),
        .rst        (rst),
        .clear      (SS_n),
        .sample     (sample_s),
        .mosi       (MOSI),
        .frame_done (frame_done_s),
        .frame      (frame_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; deselect overrides everything.
    always_comb begin
        state_next_s = state_r;
        if (SS_n) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: state_next_s = RX;
                RX: begin
                    if (frame_done_s && (cmd_s == READ_DATA_)) begin
                        state_next_s = RD_WAIT;
                    end else begin
                        state_next_s = RX;
                    end
                end
                RD_WAIT: state_next_s = RD_LOAD;
                RD_LOAD: state_next_s = TX;
                TX: begin
                    if (tx_last_s) begin
                        state_next_s = RX;
                    end else begin
                        state_next_s = TX;
                    end
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Command decode: address registers and RAM strobes. frame_done is only
    // raised with SS_n low, so a partial frame never reaches this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_r   <= '0;
            rd_addr_r   <= '0;
            ram_we_r    <= 1'b0;
            ram_re_r    <= 1'b0;
            ram_addr_r  <= '0;
            ram_wdata_r <= '0;
        end else begin
            ram_we_r <= 1'b0;
            ram_re_r <= 1'b0;
            if (frame_done_s) begin
                case (cmd_s)
                    STORE_WR_ADDR: wr_addr_r <= payload_addr_s;
                    WRITE_DATA: begin
                        ram_we_r    <= 1'b1;
                        ram_addr_r  <= wr_addr_r;
                        ram_wdata_r <= payload_s;
                        wr_addr_r   <= wr_addr_r + addr_step_s;
                    end
                    STORE_RD_ADDR: rd_addr_r <= payload_addr_s;
                    READ_DATA_: begin
                        ram_re_r   <= 1'b1;
                        ram_addr_r <= rd_addr_r;
                        rd_addr_r  <= rd_addr_r + addr_step_s;
                    end
                    default: ram_we_r <= 1'b0;
                endcase
            end
        end
    end

    // TX shifter: load the RAM word in RD_LOAD, then one bit per edge.
    // MISO idles at 0 in every other situation, including deselect.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift_r <= '0;
            tx_cnt_r   <= '0;
            miso_r     <= 1'b0;
        end else begin
            miso_r <= 1'b0;
            if (!SS_n && (state_r == RD_LOAD)) begin
                tx_shift_r <= ram_rdata;
                tx_cnt_r   <= '0;
                miso_r     <= ram_rdata[DATA_SIZE-1];
            end else if (!SS_n && (state_r == TX) && !tx_last_s) begin
                tx_shift_r <= tx_shift_next_s;
                tx_cnt_r   <= tx_cnt_r + TX_CNT_W'(1);
                miso_r     <= tx_shift_next_s[DATA_SIZE-1];
            end else begin
                tx_cnt_r <= tx_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_burst_slave
// Drives two instances (AUTO_INC=1 and AUTO_INC=0) with the same serial
// stream. Each has its own behavioural RAM; a frame-level model tracks the
// address registers and memory contents and predicts strobes and MISO bits.
// -----------------------------------------------------------------------------
module tb_spi_ram_burst_slave;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int FL = 2 + DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic SS_n;
    logic MOSI;

    logic          miso  [2];
    logic          we    [2];
    logic          re    [2];
    logic          busy  [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic [DW-1:0] rdata [2];

    spi_ram_burst_slave #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .AUTO_INC(1)) dut_inc (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso[0]),
        .ram_addr(addr[0]), .ram_wdata(wdata[0]), .ram_we(we[0]), .ram_re(re[0]),
        .ram_rdata(rdata[0]), .busy(busy[0])
    );

    spi_ram_burst_slave #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .AUTO_INC(0)) dut_hold (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso[1]),
        .ram_addr(addr[1]), .ram_wdata(wdata[1]), .ram_we(we[1]), .ram_re(re[1]),
        .ram_rdata(rdata[1]), .busy(busy[1])
    );

    // Initial RAM image, shared by the bench RAMs and the model.
    function automatic logic [7:0] init_val(input int a);
        logic [7:0] v;
        if (a == 16'h10)      v = 8'hA5;
        else if (a == 16'h11) v = 8'h3C;
        else                  v = 8'(a * 7) ^ 8'h5C;
        return v;
    endfunction

    // Behavioural single-port RAMs, read data valid the cycle after re.
    logic [DW-1:0] ram [2][256];
    initial begin
        for (int d = 0; d < 2; d++) begin
            rdata[d] <= '0;
            for (int a = 0; a < 256; a++) ram[d][a] <= init_val(a);
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (re[d]) rdata[d] <= ram[d][addr[d]];
                if (we[d]) ram[d][addr[d]] <= wdata[d];
            end
        end
    end

    // Reference model state
    logic [DW-1:0] m_mem [2][256];
    logic [AW-1:0] m_wr [2];
    logic [AW-1:0] m_rd [2];
    int            m_inc [2];

    // Expectations for the next sampled cycle
    logic          pend_we [2];
    logic          pend_re [2];
    logic [AW-1:0] pend_addr [2];
    logic [DW-1:0] pend_wdata [2];
    logic          exp_miso [2];
    logic [DW-1:0] rd_word [2];
    logic          exp_busy;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: check everything predicted for the cycle just ended,
    // then drive the inputs for the next rising edge.
    task automatic tick(input logic ss, input logic mosi, input logic r, input logic zero);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("d%0d_we", d), 32'(we[d]), 32'(pend_we[d]));
            check_val($sformatf("d%0d_re", d), 32'(re[d]), 32'(pend_re[d]));
            if (pend_we[d] || pend_re[d])
                check_val($sformatf("d%0d_addr", d), 32'(addr[d]), 32'(pend_addr[d]));
            if (pend_we[d])
                check_val($sformatf("d%0d_wdata", d), 32'(wdata[d]), 32'(pend_wdata[d]));
            if (zero) begin
                check_val($sformatf("d%0d_addr_rst", d), 32'(addr[d]), 32'd0);
                check_val($sformatf("d%0d_wdata_rst", d), 32'(wdata[d]), 32'd0);
            end
            check_val($sformatf("d%0d_miso", d), 32'(miso[d]), 32'(exp_miso[d]));
            check_val($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(exp_busy));
            pend_we[d]  = 1'b0;
            pend_re[d]  = 1'b0;
            exp_miso[d] = 1'b0;
        end
        SS_n     = ss;
        MOSI     = mosi;
        rst      = r;
        exp_busy = !ss && !r;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_wr[d] = '0;
            m_rd[d] = '0;
        end
    endtask

    // Sends a frame. abort_at >= 0: only that many bits, then SS_n rises.
    // rst_tx >= 0: reset is asserted on that TX bit of a READ_DATA frame.
    task automatic send_frame(input logic [1:0] cmd, input logic [DW-1:0] payload,
                              input int abort_at, input int rst_tx);
        logic [FL-1:0] f;
        int nb;
        f  = {cmd, payload};
        nb = (abort_at >= 0) ? abort_at : FL;
        for (int i = 0; i < nb; i++) tick(1'b0, f[FL-1-i], 1'b0, 1'b0);
        if (abort_at >= 0) begin
            tick(1'b1, 1'($urandom), 1'b0, 1'b0);
            return;
        end
        for (int d = 0; d < 2; d++) begin
            case (cmd)
                2'b00: m_wr[d] = payload[AW-1:0];
                2'b01: begin
                    pend_we[d]    = 1'b1;
                    pend_addr[d]  = m_wr[d];
                    pend_wdata[d] = payload;
                    m_mem[d][m_wr[d]] = payload;
                    m_wr[d] = AW'((int'(m_wr[d]) + m_inc[d]) % 256);
                end
                2'b10: m_rd[d] = payload[AW-1:0];
                default: begin
                    pend_re[d]   = 1'b1;
                    pend_addr[d] = m_rd[d];
                    rd_word[d]   = m_mem[d][m_rd[d]];
                    m_rd[d] = AW'((int'(m_rd[d]) + m_inc[d]) % 256);
                end
            endcase
        end
        if (cmd == 2'b11) begin
            tick(1'b0, 1'($urandom), 1'b0, 1'b0);
            tick(1'b0, 1'($urandom), 1'b0, 1'b0);
            for (int k = DW - 1; k >= 1; k--) begin
                for (int d = 0; d < 2; d++) exp_miso[d] = rd_word[d][k];
                if (rst_tx == DW - 1 - k) begin
                    tick(1'b0, 1'($urandom), 1'b1, 1'b0);
                    model_reset();
                    tick(1'b1, 1'b0, 1'b0, 1'b1);
                    return;
                end
                tick(1'b0, 1'($urandom), 1'b0, 1'b0);
            end
            for (int d = 0; d < 2; d++) exp_miso[d] = rd_word[d][0];
        end
    endtask

    initial begin
        rst = 1'b1;
        SS_n = 1'b1;
        MOSI = 1'b0;
        exp_busy = 1'b0;
        m_inc[0] = 1;
        m_inc[1] = 0;
        for (int d = 0; d < 2; d++) begin
            pend_we[d] = 1'b0;
            pend_re[d] = 1'b0;
            pend_addr[d] = '0;
            pend_wdata[d] = '0;
            exp_miso[d] = 1'b0;
            rd_word[d] = '0;
            for (int a = 0; a < 256; a++) m_mem[d][a] = init_val(a);
        end
        model_reset();

        // Reset state
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);

        // Burst read of preloaded 0x10/0x11
        send_frame(2'b10, 8'h10, -1, -1);
        send_frame(2'b11, 8'($urandom), -1, -1);
        send_frame(2'b11, 8'($urandom), -1, -1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);

        // Write burst with increment
        send_frame(2'b00, 8'h10, -1, -1);
        send_frame(2'b01, 8'hA5, -1, -1);
        send_frame(2'b01, 8'h5A, -1, -1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);

        // Address wrap
        send_frame(2'b00, 8'hFF, -1, -1);
        send_frame(2'b01, 8'h01, -1, -1);
        send_frame(2'b01, 8'h02, -1, -1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);

        // Aborted WRITE_DATA after 5 bits, then a normal write
        send_frame(2'b00, 8'h40, -1, -1);
        send_frame(2'b01, 8'h99, 5, -1);
        send_frame(2'b01, 8'h66, -1, -1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);

        // Hold-address behaviour (visible on the AUTO_INC=0 instance)
        send_frame(2'b00, 8'h20, -1, -1);
        send_frame(2'b01, 8'h11, -1, -1);
        send_frame(2'b01, 8'h22, -1, -1);

        // Reset in the middle of TX, then normal decoding
        send_frame(2'b10, 8'h20, -1, -1);
        send_frame(2'b11, 8'h00, -1, 3);
        send_frame(2'b01, 8'h77, -1, -1);
        send_frame(2'b11, 8'h00, -1, -1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                tick(1'b1, 1'($urandom), 1'b0, 1'b0);
            end
            if (r == 1) begin
                send_frame(2'($urandom), 8'($urandom), int'($urandom_range(1, FL - 1)), -1);
            end else begin
                send_frame(2'($urandom), 8'($urandom), -1, -1);
            end
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
